// File: rtl/bias_loader.sv
// -----------------------------------------------------------------------------
// bias_loader
//
// Runtime writer for the per-channel bias bank. Bias words arrive one per beat
// on a valid/ready stream. They are packed into a shadow bank and then copied
// to the active bank. The copy waits while the compute engine holds lock_i, so
// a layer in flight always sees a stable set of biases.
//
// Ports
//   clk_i         clock, single domain
//   rst_ni        synchronous active-low reset; clears both banks
//   start_i       begin a new load; only honoured in IDLE
//   s_valid_i     bias word valid
//   s_ready_o     loader accepts a word (decoded from the registered state)
//   s_data_i      bias word, two's complement, stored bit-exact
//   s_last_i      final word of a load packet
//   lock_i        active bank in use; the commit waits while this is high
//   data_o        active bank, packed [NUM_CH-1:0][WIDTH-1:0]
//   bias_valid_o  active bank holds a committed set (sticky until reset)
//   busy_o        FSM not in IDLE
//   done_o        one-cycle pulse in the cycle a commit becomes visible
//   err_o         sticky packet-length error, cleared by the next start
//
// State table
//   IDLE   | waiting for start_i, stream not ready
//   LOAD   | accepting words into the shadow bank
//   FLUSH  | packet too long: discard words up to and including s_last_i
//   COMMIT | shadow complete; copy to active bank once lock_i is low
// -----------------------------------------------------------------------------
module bias_loader #(
    // Defaults match K_CHANNELS / ACC_WIDTH of the accelerator configuration.
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [WIDTH-1:0]               s_data_i,
    input  logic                           s_last_i,
    input  logic                           lock_i,
    output logic [NUM_CH-1:0][WIDTH-1:0]   data_o,
    output logic                           bias_valid_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FLUSH  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                         state_q, state_nxt;
    logic [CW-1:0]                  cnt_q, cnt_nxt;
    logic                           err_q, err_nxt;
    logic                           done_q, done_nxt;
    logic                           valid_q;
    logic                           shadow_we;
    logic                           commit;
    logic                           beat;
    logic [NUM_CH-1:0][WIDTH-1:0]   shadow_q;
    logic [NUM_CH-1:0][WIDTH-1:0]   active_q;

    // Ready depends only on the registered state, never on s_valid_i.
    assign s_ready_o = (state_q == LOAD) || (state_q == FLUSH);
    assign beat      = s_valid_i && s_ready_o;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        done_nxt  = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (beat) begin
                    shadow_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        // Counter holds at the last index instead of wrapping.
                        if (s_last_i) begin
                            state_nxt = COMMIT;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = FLUSH;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                        if (s_last_i) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            FLUSH: begin
                if (beat && s_last_i) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                if (!lock_i) begin
                    commit    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            done_q  <= done_nxt;
            // Word i lands in channel NUM_CH-1-i so the first word drives
            // the top channel, matching the bias store hex-file order.
            if (shadow_we) begin
                shadow_q[LAST_IDX - cnt_q] <= s_data_i;
            end
            if (commit) begin
                active_q <= shadow_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign data_o       = active_q;
    assign bias_valid_o = valid_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bias_loader.sv
module tb_bias_loader;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 start_i;
    logic                 s_valid_i;
    logic                 s_ready_o;
    logic [31:0]          s_data_i;
    logic                 s_last_i;
    logic                 lock_i;
    logic [3:0][31:0]     data_o;
    logic                 bias_valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    localparam logic [127:0] SET_A = {32'h00000011, 32'h00000022, 32'hFFFFFF33, 32'h00000044};
    localparam logic [127:0] SET_B = {32'hA5A5A5A5, 32'h00000001, 32'h80000000, 32'h7FFFFFFF};
    localparam logic [127:0] SET_C = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    localparam logic [127:0] SET_D = {32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF};

    bias_loader #(.NUM_CH(4), .WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .s_last_i     (s_last_i),
        .lock_i       (lock_i),
        .data_o       (data_o),
        .bias_valid_o (bias_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_ni && s_valid_i && s_ready_o) acc_cnt <= acc_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Drive one word until accepted (bounded); then gap idle cycles.
    task automatic send_word(input logic [31:0] d, input logic l, input int gap);
        bit ok;
        ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = s_ready_o;
            tick();
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_set(input logic [127:0] set, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_word(set[127 - 32*i -: 32], (i == 3), gap);
        end
    endtask

    task automatic wait_done(output int waited);
        waited = 0;
        while (!done_o && waited < 20) begin
            tick();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_i   = 1'($urandom);
            s_valid_i = 1'($urandom);
            s_data_i  = $urandom;
            s_last_i  = 1'($urandom);
            lock_i    = 1'($urandom);
            tick();
        end
        checks++;
        if ({s_ready_o, bias_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {s_ready_o, bias_valid_o, busy_o, done_o, err_o});
        end
        checks++;
        if (data_o !== 128'b0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", data_o);
        end
        start_i = 0; s_valid_i = 0; s_data_i = 0; s_last_i = 0; lock_i = 0;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_normal_load();
        int c0, w, d0;
        d0 = done_cnt;
        c0 = cyc;
        pulse_start();
        checks++;
        if (s_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL normal_ready got %b%b exp 11", s_ready_o, busy_o);
        end
        send_set(SET_A, 0);
        wait_done(w);
        checks++;
        if (done_o !== 1'b1 || (cyc - c0) != 6) begin
            errors++;
            $display("FAIL normal_latency got done=%b cycles=%0d exp done=1 cycles=6", done_o, cyc - c0);
        end
        checks++;
        if (data_o !== SET_A || bias_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL normal_data got %h v=%b b=%b exp %h v=1 b=0", data_o, bias_valid_o, busy_o, SET_A);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL normal_done_width got done=%b pulses=%0d exp 0 1", done_o, done_cnt - d0);
        end
    endtask

    task automatic test_lock_deferral();
        int w, d0;
        d0 = done_cnt;
        lock_i = 1'b1;
        pulse_start();
        send_set(SET_B, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_ready_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0 || data_o !== SET_A) begin
                errors++;
                $display("FAIL lock_hold%0d got r=%b b=%b d=%b data=%h exp r=0 b=1 d=0 data=%h",
                         i, s_ready_o, busy_o, done_o, data_o, SET_A);
            end
            tick();
        end
        lock_i = 1'b0;
        tick();
        checks++;
        if (done_o !== 1'b1 || data_o !== SET_B || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL lock_release got d=%b data=%h prior=%0d exp d=1 data=%h prior=0",
                     done_o, data_o, done_cnt - d0, SET_B);
        end
        wait_done(w);
        tick();
    endtask

    task automatic test_valid_gaps();
        int w, a0;
        a0 = acc_cnt;
        pulse_start();
        send_set(SET_A, 2);
        wait_done(w);
        checks++;
        if (data_o !== SET_A || acc_cnt - a0 != 4) begin
            errors++;
            $display("FAIL gaps_data got %h beats=%0d exp %h beats=4", data_o, acc_cnt - a0, SET_A);
        end
        tick();
    endtask

    task automatic test_length_errors();
        int w, d0, a0;
        d0 = done_cnt;
        pulse_start();
        send_word(32'h1111_1111, 1'b0, 0);
        send_word(32'h2222_2222, 1'b1, 0);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || data_o !== SET_A || bias_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL early_last got e=%b b=%b v=%b data=%h exp e=1 b=0 v=1 data=%h",
                     err_o, busy_o, bias_valid_o, data_o, SET_A);
        end
        pulse_start();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_start got %b exp 0", err_o);
        end
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) send_word(32'h3333_0000 + i, 1'b0, 0);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b1 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL missing_last_flush got e=%b b=%b r=%b exp 111", err_o, busy_o, s_ready_o);
        end
        send_word(32'h4444_4444, 1'b0, 0);
        send_word(32'h5555_5555, 1'b1, 0);
        repeat (3) tick();
        checks++;
        if (acc_cnt - a0 != 6 || err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt - d0 != 0 || data_o !== SET_A) begin
            errors++;
            $display("FAIL missing_last_end got beats=%0d e=%b b=%b dones=%0d data=%h exp 6 1 0 0 %h",
                     acc_cnt - a0, err_o, busy_o, done_cnt - d0, data_o, SET_A);
        end
        pulse_start();
        send_set(SET_C, 0);
        wait_done(w);
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b1 || data_o !== SET_C) begin
            errors++;
            $display("FAIL recover_load got e=%b d=%b data=%h exp e=0 d=1 data=%h", err_o, done_o, data_o, SET_C);
        end
        tick();
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_word(32'hAAAA_0001, 1'b0, 0);
        send_word(32'hAAAA_0002, 1'b0, 0);
        rst_ni = 1'b0;
        tick();
        checks++;
        if (data_o !== 128'b0 || bias_valid_o !== 1'b0 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload got data=%h v=%b b=%b r=%b exp 0 0 0 0", data_o, bias_valid_o, busy_o, s_ready_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_start_while_busy();
        int w, d0;
        d0 = done_cnt;
        pulse_start();
        send_word(SET_D[127:96], 1'b0, 0);
        start_i = 1'b1;
        send_word(SET_D[95:64], 1'b0, 0);
        start_i = 1'b0;
        send_word(SET_D[63:32], 1'b0, 0);
        send_word(SET_D[31:0], 1'b1, 0);
        wait_done(w);
        checks++;
        if (done_o !== 1'b1 || data_o !== SET_D || bias_valid_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL start_busy got d=%b data=%h v=%b e=%b exp d=1 data=%h v=1 e=0",
                     done_o, data_o, bias_valid_o, err_o, SET_D);
        end
        tick();
        checks++;
        if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_once got dones=%0d b=%b exp 1 0", done_cnt - d0, busy_o);
        end
    endtask

    initial begin
        rst_ni = 0; start_i = 0; s_valid_i = 0; s_data_i = 0; s_last_i = 0; lock_i = 0;
        test_reset();
        test_normal_load();
        test_lock_deferral();
        test_valid_gaps();
        test_length_errors();
        test_reset_midload();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
- Runtime writer counterpart to the read-only bias store.
- Accepts one bias word per output channel over a valid/ready stream and packs the words into a shadow register bank.
- Commits the shadow bank to an active bank only while the compute engine is not locked.
- Presents all channel biases in parallel to the bias-add stage, so a new layer's biases can be loaded without re-synthesis and without disturbing a layer in flight.

Parameters:
- NUM_CH, default K_CHANNELS (package constant), number of output channels = bias words per load.
- WIDTH, default ACC_WIDTH (package constant), bits per bias word.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  pulse; begin a new load (honoured in IDLE only).
- s_valid_i  in  1  bias word valid.
- s_ready_o  out  1  loader can accept a word.
- s_data_i  in  WIDTH  bias word, two's complement.
- s_last_i  in  1  marks the final word of a load packet.
- lock_i  in  1  compute engine is using the active bank; commit is deferred while high.
- data_o  out  NUM_CH x WIDTH  active bank, packed [NUM_CH-1:0][WIDTH-1:0].
- bias_valid_o  out  1  active bank holds a committed set.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when a commit lands.
- err_o  out  1  sticky packet-length error; cleared by the next accepted start_i.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - State goes to IDLE and the beat counter to 0.
  - Shadow bank and active bank go to 0.
  - All outputs are 0.
  - Reset mid-load discards everything, including the previously committed active bank.
- Handshake:
  - A beat transfers when s_valid_i & s_ready_o are high at a clock edge.
  - s_ready_o is a registered-state decode and has no combinational path from s_valid_i.
  - Source holds s_data_i and s_last_i stable while s_valid_i=1 and s_ready_o=0.
- Channel ordering: the i-th accepted word (i=0..NUM_CH-1) is written to shadow[NUM_CH-1-i]. This matches hex-file order of the bias store, so word 0 drives the top channel.
- FSM states:
  - IDLE: s_ready_o=0. start_i=1 -> LOAD, counter<=0, err_o<=0. s_ready_o=1 from the next cycle.
  - LOAD: s_ready_o=1. On each beat, write shadow and increment the counter.
    - Beat with counter<NUM_CH-1 and s_last_i=1 (early last): err_o<=1 -> IDLE. Active bank untouched.
    - Beat with counter==NUM_CH-1 and s_last_i=1 -> COMMIT.
    - Beat with counter==NUM_CH-1 and s_last_i=0 (missing last): err_o<=1 -> FLUSH.
  - FLUSH: s_ready_o=1. Accept and discard beats. Beat with s_last_i=1 -> IDLE. Shadow not written.
  - COMMIT: s_ready_o=0.
    - lock_i=0: active<=shadow, bias_valid_o<=1, done_o<=1 (registered) -> IDLE.
    - lock_i=1: stay in COMMIT.
- Timing:
  - New data_o, bias_valid_o=1 and done_o=1 become visible together in the cycle after the COMMIT edge.
  - done_o lasts exactly one cycle.
  - Minimum latency from start_i to done_o is NUM_CH+2 cycles with continuous valid and lock_i=0.
- bias_valid_o: once set, stays 1 until reset. Errors never clear it or alter data_o.
- data_o: driven directly from active-bank flops; stable except at a commit edge.
- start_i: ignored in LOAD, FLUSH and COMMIT (no restart, err_o not cleared).
- No arithmetic on data; words are stored bit-exact. The counter is $clog2(NUM_CH) bits min 1 and never wraps past NUM_CH-1.

Test Plan (NUM_CH=4, WIDTH=32):
- Reset: hold rst_ni=0 for 3 cycles with random inputs -> all outputs 0, data_o all 0.
- Normal load:
  - Stimulus: start_i, then 0x00000011, 0x00000022, 0xFFFFFF33, 0x00000044 on consecutive cycles with last on the 4th, lock_i=0.
  - Response: done_o pulses at cycle 6 after start. data_o[3]=0x11, [2]=0x22, [1]=0xFFFFFF33, [0]=0x44. bias_valid_o=1, busy_o=0.
- Valid gaps: same words with s_valid_i low for 2 cycles between beats -> identical data_o. Each word is accepted exactly once.
- Lock deferral:
  - Stimulus: lock_i=1 during load and for 5 cycles after the last beat.
  - Response: s_ready_o=0, busy_o=1, data_o keeps the previous set. done_o fires 1 cycle after lock_i falls.
- Length errors:
  - Early last on the 2nd word -> err_o=1, state IDLE, data_o unchanged.
  - Missing last: 4 words with no last, then 2 extra words with last on the 2nd -> extras accepted, err_o=1, no done_o, data_o unchanged.
  - A following good load clears err_o.
- Reset mid-load and start while busy:
  - Stimulus: after a good commit, start a new load and apply rst_ni=0 after 2 beats.
  - Response: data_o=0, bias_valid_o=0.
  - Separately, start_i pulsed during LOAD is ignored and the load completes normally.
